// File: rtl/pwm_compare_pkg.sv
// Shared definitions for the PWM compare stage: FSM state encoding,
// the default timebase width and a small state-decoding helper.
package pwm_compare_pkg;

   // Default timebase width; one PWM period is 2**width cycles.
   localparam int PWM_DEFAULT_WIDTH = 8;

   // Enable/disable sequencing states.
   //   IDLE  : output off, waiting for enable
   //   SYNC  : enable seen, waiting for the next period boundary
   //   RUN   : output active, enable high
   //   DRAIN : enable dropped, finishing the current period
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } pwm_state_e;

   // True in the states where the compare result drives the output.
   function automatic logic state_drives_output(pwm_state_e s);
      return (s == RUN) || (s == DRAIN);
   endfunction

endpackage

// File: rtl/pwm_duty_shadow.sv
// Duty staging for the PWM compare stage. A duty value enters a shadow
// register through a valid/ready handshake and moves to the active duty
// only on a period boundary, so a running period is never modified.
// duty_cur_o is the duty that governs the cycle being compared right now:
// on an applying boundary that is already the shadow value.
module pwm_duty_shadow
   import pwm_compare_pkg::*;
#(
   parameter int WIDTH = PWM_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             boundary_i,
   input  logic             duty_valid_i,
   input  logic [WIDTH-1:0] duty_data_i,
   output logic             duty_ready_o,
   output logic             pending_o,
   output logic [WIDTH-1:0] duty_cur_o
);

   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] active_q, active_d;
   logic             pending_q, pending_d;
   logic             accept;
   logic             apply;

   // Only one value may wait in the shadow; a second load stalls until
   // the boundary that consumes the first one.
   assign accept = duty_valid_i && !pending_q;
   assign apply  = boundary_i && pending_q;

   // Next-state for shadow, pending flag and active duty.
   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      // apply and accept are mutually exclusive (apply needs pending,
      // accept needs !pending), so a load taken on a boundary cycle
      // always waits for the following boundary.
      if (apply) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      if (accept) begin
         shadow_d  = duty_data_i;
         pending_d = 1'b1;
      end
   end

   // Staging registers; reset also discards any load offered in that cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q  <= '0;
         active_q  <= '0;
         pending_q <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
      end
   end

   assign duty_cur_o   = apply ? shadow_q : active_q;
   assign pending_o    = pending_q;
   assign duty_ready_o = !pending_q;

endmodule

// File: rtl/pwm_compare.sv
// PWM compare stage driven by an external free-running timebase.
// The output is high while count < duty, with duty changes and
// enable/disable taking effect only at period boundaries (count == 0).
// Optional build macro PWM_COMPARE_SEQ_CHECK_EN adds a timebase
// continuity check with a sticky seq_err flag; without it seq_err is 0.
module pwm_compare
   import pwm_compare_pkg::*;
#(
   parameter int WIDTH = PWM_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] count,
   input  logic             enable,
   input  logic             duty_valid,
   input  logic [WIDTH-1:0] duty_data,
   output logic             duty_ready,
   output logic             pending,
   output logic             pwm_out,
   output logic             period_tick,
   output logic             seq_err
);

   pwm_state_e       state_q, state_d;
   logic             pwm_q, pwm_d;
   logic             tick_q;
   logic             boundary;
   logic             seq_disc;
   logic [WIDTH-1:0] duty_cur;

   assign boundary = (count == '0);

   pwm_duty_shadow #(
      .WIDTH (WIDTH)
   ) u_duty_shadow (
      .clk          (clk),
      .reset        (reset),
      .boundary_i   (boundary),
      .duty_valid_i (duty_valid),
      .duty_data_i  (duty_data),
      .duty_ready_o (duty_ready),
      .pending_o    (pending),
      .duty_cur_o   (duty_cur)
   );

`ifdef PWM_COMPARE_SEQ_CHECK_EN
   logic [WIDTH-1:0] prev_count_q;
   logic [WIDTH-1:0] count_expect;
   logic             prev_valid_q;
   logic             seq_err_q;

   assign count_expect = prev_count_q + 1'b1;

   // A jump only matters while the output is being generated; in IDLE
   // and SYNC the next boundary re-aligns everything anyway.
   assign seq_disc = prev_valid_q && (count != count_expect)
                     && state_drives_output(state_q);

   // Track the previous timebase sample and latch discontinuities.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_count_q <= '0;
         prev_valid_q <= 1'b0;
         seq_err_q    <= 1'b0;
      end else begin
         prev_count_q <= count;
         prev_valid_q <= 1'b1;
         if (seq_disc) begin
            seq_err_q <= 1'b1;
         end
      end
   end

   assign seq_err = seq_err_q;
`else
   assign seq_disc = 1'b0;
   assign seq_err  = 1'b0;
`endif

   // Enable sequencing with whole-period granularity, plus output compare.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = SYNC;
            end
         end
         SYNC: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (boundary) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!enable) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (enable) begin
               state_d = RUN;
            end else if (boundary) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // A broken timebase invalidates the current period: resynchronise
      // on the next boundary if still enabled.
      if (seq_disc) begin
         state_d = enable ? SYNC : IDLE;
      end
      // Decided from the next state so the first high cycle lines up with
      // the boundary that enters RUN and the last period of DRAIN completes.
      pwm_d = state_drives_output(state_d) && (count < duty_cur) && !seq_disc;
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pwm_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pwm_q   <= pwm_d;
         tick_q  <= boundary;
      end
   end

   assign pwm_out     = pwm_q;
   assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_compare.sv
// Self-checking bench for pwm_compare. The reference model reasons about
// periods: a period is generated when the block was already running and
// enable was high at its boundary or the cycle before, or when it was idle
// and enable was high both at the boundary and the cycle before. Duty values
// queue one deep and take effect at the next boundary.
module tb_pwm_compare;

   localparam int W = 8;
   localparam int PERIOD = 1 << W;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] count;
   logic         enable;
   logic         duty_valid;
   logic [W-1:0] duty_data;
   logic         duty_ready;
   logic         pending;
   logic         pwm_out;
   logic         period_tick;
   logic         seq_err;

   int errors = 0;
   int checks = 0;

   // Reference model state
   bit m_pending, m_running, m_en_prev, m_prev_valid, m_seq_err, m_pwm, m_tick;
   int m_shadow, m_active, m_prev_count;

   always #5 clk = ~clk;

   pwm_compare #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .count       (count),
      .enable      (enable),
      .duty_valid  (duty_valid),
      .duty_data   (duty_data),
      .duty_ready  (duty_ready),
      .pending     (pending),
      .pwm_out     (pwm_out),
      .period_tick (period_tick),
      .seq_err     (seq_err)
   );

   // One clock: predict from the inputs present before the edge, then
   // update the model once outputs have settled after the edge.
   task automatic step();
      bit b, disc, n_run, n_pend, n_pwm, n_tick, n_seq, n_pv, n_en;
      int duty_now, n_shadow, n_active, n_pc;
      if (reset) begin
         n_run = 0; n_pend = 0; n_pwm = 0; n_tick = 0; n_seq = 0; n_pv = 0;
         n_en = 0; n_shadow = 0; n_active = 0; n_pc = 0;
      end else begin
         b = (count == 0);
         duty_now = (b && m_pending) ? m_shadow : m_active;
         n_shadow = m_shadow;
         n_active = duty_now;
         n_pend = m_pending && !b;
         if (duty_valid && !m_pending) begin
            n_shadow = int'(duty_data);
            n_pend = 1;
         end
         n_run = m_running;
         if (b) n_run = m_running ? (m_en_prev || enable) : (m_en_prev && enable);
         disc = 0;
`ifdef PWM_COMPARE_SEQ_CHECK_EN
         disc = m_prev_valid && m_running && (int'(count) != (m_prev_count + 1) % PERIOD);
`endif
         n_seq = m_seq_err || disc;
         if (disc) n_run = 0;
         n_pwm = n_run && (int'(count) < duty_now);
         n_tick = b;
         n_pv = 1;
         n_pc = int'(count);
         n_en = enable;
      end
      @(posedge clk);
      #1;
      m_running = n_run; m_pending = n_pend; m_pwm = n_pwm; m_tick = n_tick;
      m_seq_err = n_seq; m_prev_valid = n_pv; m_en_prev = n_en;
      m_shadow = n_shadow; m_active = n_active; m_prev_count = n_pc;
   endtask

   // Advance n cycles with a continuous timebase, comparing every cycle
   // against the model and counting high cycles and ticks.
   task automatic run_cycles(input int n, output int highs, output int ticks);
      logic [4:0] act, exp;
      highs = 0;
      ticks = 0;
      for (int i = 0; i < n; i++) begin
         step();
         count = count + 1'b1;
         act = {pwm_out, period_tick, pending, duty_ready, seq_err};
         exp = {m_pwm, m_tick, m_pending, !m_pending, m_seq_err};
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL cycle t=%0t {pwm,tick,pend,rdy,err} actual=%b required=%b",
                     $time, act, exp);
         end
         if (pwm_out === 1'b1) highs++;
         if (period_tick === 1'b1) ticks++;
      end
   endtask

   task automatic to_zero();
      int h, t;
      for (int i = 0; i < PERIOD && count != 0; i++) run_cycles(1, h, t);
   endtask

   task automatic load_duty(input int d);
      int h, t, waited;
      waited = 0;
      while (duty_ready !== 1'b1 && waited < 600) begin
         run_cycles(1, h, t);
         waited++;
      end
      checks++;
      if (duty_ready !== 1'b1) begin
         errors++;
         $display("FAIL load_wait duty_ready actual=%b required=1", duty_ready);
      end
      duty_valid = 1'b1;
      duty_data = W'(d);
      run_cycles(1, h, t);
      duty_valid = 1'b0;
   endtask

   task automatic test_reset();
      int h, t;
      reset = 1'b1; enable = 1'b1; duty_valid = 1'b1; duty_data = 8'd77; count = '0;
      run_cycles(2, h, t);
      reset = 1'b0; enable = 1'b0; duty_valid = 1'b0;
      checks += 5;
      if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm actual=%b required=0", pwm_out); end
      if (period_tick !== 1'b0) begin errors++; $display("FAIL reset_tick actual=%b required=0", period_tick); end
      if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending actual=%b required=0", pending); end
      if (duty_ready !== 1'b1) begin errors++; $display("FAIL reset_ready actual=%b required=1", duty_ready); end
      if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err actual=%b required=0", seq_err); end
   endtask

   task automatic test_basic();
      int h, t;
      load_duty(64);
      while (count != 8'd100) run_cycles(1, h, t);
      enable = 1'b1;
      run_cycles(PERIOD - 100, h, t);
      checks++;
      if (h != 0) begin errors++; $display("FAIL basic_sync_highs actual=%0d required=0", h); end
      for (int p = 0; p < 2; p++) begin
         run_cycles(PERIOD, h, t);
         checks += 2;
         if (h != 64) begin errors++; $display("FAIL basic_highs actual=%0d required=64", h); end
         if (t != 1) begin errors++; $display("FAIL basic_ticks actual=%0d required=1", t); end
      end
   endtask

   task automatic test_update();
      int h1, h2, h3, h4, t;
      run_cycles(10, h1, t);
      duty_valid = 1'b1; duty_data = 8'd200;
      run_cycles(1, h2, t);
      duty_valid = 1'b0;
      run_cycles(PERIOD - 12, h3, t);
      checks++;
      if (duty_ready !== 1'b0) begin errors++; $display("FAIL update_ready_before_boundary actual=%b required=0", duty_ready); end
      run_cycles(1, h4, t);
      checks++;
      if (h1 + h2 + h3 + h4 != 64) begin errors++; $display("FAIL update_current_highs actual=%0d required=64", h1 + h2 + h3 + h4); end
      run_cycles(PERIOD, h1, t);
      checks++;
      if (h1 != 200) begin errors++; $display("FAIL update_next_highs actual=%0d required=200", h1); end
   endtask

   task automatic test_boundary_load();
      int h1, h2, t;
      duty_valid = 1'b1; duty_data = 8'd100;
      run_cycles(1, h1, t);
      duty_valid = 1'b0;
      checks++;
      if (pending !== 1'b1) begin errors++; $display("FAIL bnd_load_pending actual=%b required=1", pending); end
      run_cycles(PERIOD - 1, h2, t);
      checks++;
      if (h1 + h2 != 200) begin errors++; $display("FAIL bnd_load_same_period actual=%0d required=200", h1 + h2); end
      run_cycles(PERIOD, h1, t);
      checks++;
      if (h1 != 100) begin errors++; $display("FAIL bnd_load_next_period actual=%0d required=100", h1); end
   endtask

   task automatic test_extremes();
      int h, t;
      int duties[2] = '{0, 255};
      foreach (duties[i]) begin
         load_duty(duties[i]);
         to_zero();
         run_cycles(PERIOD, h, t);
         checks++;
         if (h != duties[i]) begin errors++; $display("FAIL extreme_duty%0d actual=%0d required=%0d", duties[i], h, duties[i]); end
      end
   endtask

   task automatic test_disable();
      int h1, h2, t;
      load_duty(128);
      to_zero();
      run_cycles(30, h1, t);
      enable = 1'b0;
      run_cycles(PERIOD - 30, h2, t);
      checks++;
      if (h1 + h2 != 128) begin errors++; $display("FAIL disable_last_period actual=%0d required=128", h1 + h2); end
      for (int p = 0; p < 2; p++) begin
         run_cycles(PERIOD, h1, t);
         checks++;
         if (h1 != 0) begin errors++; $display("FAIL disable_after actual=%0d required=0", h1); end
      end
   endtask

   task automatic test_reset_mid();
      int h, t;
      enable = 1'b1;
      run_cycles(2 * PERIOD, h, t);
      while (count != 8'd77) run_cycles(1, h, t);
      reset = 1'b1; duty_valid = 1'b1; duty_data = 8'd9;
      run_cycles(1, h, t);
      reset = 1'b0; duty_valid = 1'b0;
      checks += 2;
      if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_mid_pwm actual=%b required=0", pwm_out); end
      if (pending !== 1'b0) begin errors++; $display("FAIL reset_mid_pending actual=%b required=0", pending); end
      load_duty(50);
      to_zero();
      run_cycles(PERIOD, h, t);
      checks++;
      if (h != 50) begin errors++; $display("FAIL reset_mid_resume actual=%0d required=50", h); end
   endtask

   task automatic test_back_to_back();
      int h, t;
      bit accepted;
      for (int i = 0; i < 3000; i++) begin
         accepted = duty_valid && (duty_ready === 1'b1);
         if ($urandom_range(0, 199) == 0) enable = ~enable;
         run_cycles(1, h, t);
         // Data is only changed when no offer is outstanding.
         if (accepted || !duty_valid) begin
            duty_valid = ($urandom_range(0, 3) == 0);
            duty_data = W'($urandom);
         end
      end
      duty_valid = 1'b0;
   endtask

   task automatic test_seq();
      int h, t;
      enable = 1'b1;
      load_duty(128);
      to_zero();
      run_cycles(2 * PERIOD, h, t);
      run_cycles(41, h, t);
      count = 8'd90;
      run_cycles(1, h, t);
      checks += 2;
`ifdef PWM_COMPARE_SEQ_CHECK_EN
      if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_err_set actual=%b required=1", seq_err); end
      if (pwm_out !== 1'b0) begin errors++; $display("FAIL seq_pwm_off actual=%b required=0", pwm_out); end
`else
      if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_err_off actual=%b required=0", seq_err); end
      if (pwm_out !== 1'b1) begin errors++; $display("FAIL seq_pwm_ignored actual=%b required=1", pwm_out); end
`endif
      to_zero();
      run_cycles(PERIOD, h, t);
      checks += 2;
      if (h != 128) begin errors++; $display("FAIL seq_resume actual=%0d required=128", h); end
`ifdef PWM_COMPARE_SEQ_CHECK_EN
      if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_err_sticky actual=%b required=1", seq_err); end
`else
      if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_err_stays0 actual=%b required=0", seq_err); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_update();
      test_boundary_load();
      test_extremes();
      test_disable();
      test_reset_mid();
      test_back_to_back();
      test_seq();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
